msu_data_feeder: RTL

//  MCU-side writer for the MSU data port: fills the 16 KiB MSU data buffer that the SNES reads through reg 1.
//  On an SNES data seek, status bit 5 rises. The block then:
//   - fetches 16 KiB from a byte-stream source and writes it through the buffer program port;
//   - rewinds the SNES read pointer and clears data busy via the status set/reset port;
//   - double-buffers afterwards, refilling each 8 KiB half when the SNES read pointer (status bit 7) leaves it.

---
 rtl/msu_data_feeder_pkg.sv | 39 +++
 rtl/msu_data_feeder_strobe_gen.sv | 70 +++++++
 rtl/msu_data_feeder.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/msu_data_feeder_pkg.sv
// ---------------------------------------------------------------------------
// msu_pkg
// Shared definitions for the MSU data feeder: FSM state encodings, MSU status
// bit positions and buffer geometry.
// ---------------------------------------------------------------------------
package msu_pkg;

    // Feeder control states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_FILL    = 3'd2,
        ST_PRELOAD = 3'd3,
        ST_CLRBUSY = 3'd4,
        ST_STREAM  = 3'd5,
        ST_REFILL  = 3'd6
    } feed_state_e;

    // Strobe sequencer phases
    typedef enum logic [1:0] {
        SG_IDLE = 2'd0,
        SG_HIGH = 2'd1,
        SG_LOW  = 2'd2
    } strobe_phase_e;

    // MSU status bit positions
    localparam int ST_PTR13      = 7;  // SNES read pointer bit 13 (which half is being read)
    localparam int ST_DATA_START = 5;  // data seek requested
    localparam int RST_DATA_BUSY = 4;  // data busy flag in the reset/set bit vector

    // Buffer geometry
    localparam int BUF_ADDR_W = 14;
    localparam int LEN_W      = 15;
    localparam int BUF_BYTES  = 16384;

    // Bits cleared once the buffer is primed: data_start and data busy
    localparam logic [5:0] CLR_BUSY_BITS = 6'((1 << ST_DATA_START) | (1 << RST_DATA_BUSY));

endpackage

// File: rtl/msu_data_feeder_strobe_gen.sv
// ---------------------------------------------------------------------------
// msu_strobe_gen
// Produces one strobe held high for PULSE_CYC cycles followed by PULSE_CYC low
// cycles. o_done is high during the last low cycle, so a new i_start in that
// same cycle chains the next pulse with exactly PULSE_CYC low cycles between.
//
// Ports
//   clkin    in   clock
//   rst_n    in   asynchronous reset, active low
//   i_start  in   begin a pulse (accepted when idle or on the done cycle)
//   o_strobe out  registered strobe
//   o_done   out  last low cycle of the sequence
// ---------------------------------------------------------------------------
module msu_strobe_gen
    import msu_pkg::*;
#(
    parameter int PULSE_CYC = 4
) (
    input  logic clkin,
    input  logic rst_n,
    input  logic i_start,
    output logic o_strobe,
    output logic o_done
);

    localparam int CW = $clog2(PULSE_CYC + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(PULSE_CYC - 1);

    strobe_phase_e r_phase;
    logic [CW-1:0] r_cnt;
    logic          r_strobe;
    logic          w_done;

    assign w_done   = (r_phase == SG_LOW) && (r_cnt == '0);
    assign o_done   = w_done;
    assign o_strobe = r_strobe;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_phase  <= SG_IDLE;
            r_cnt    <= '0;
            r_strobe <= 1'b0;
        end else if (i_start && (r_phase == SG_IDLE || w_done)) begin
            r_phase  <= SG_HIGH;
            r_cnt    <= CNT_LOAD;
            r_strobe <= 1'b1;
        end else begin
            case (r_phase)
                SG_HIGH: begin
                    if (r_cnt == '0) begin
                        r_phase  <= SG_LOW;
                        r_cnt    <= CNT_LOAD;
                        r_strobe <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                SG_LOW: begin
                    if (r_cnt == '0) begin
                        r_phase <= SG_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_phase <= SG_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/msu_data_feeder.sv
// ---------------------------------------------------------------------------
// msu_data_feeder
// MCU-side writer for the MSU data buffer. On a data seek it fetches a full
// buffer from a byte-stream source, rewinds the SNES read pointer, clears the
// busy/start status bits and then keeps the buffer double-buffered, refilling
// each half once the SNES read pointer has moved into the other half.
//
// Ports
//   clkin, rst_n                 clock, asynchronous active-low reset
//   status_in[7:0]               MSU status ([7] read-ptr bit 13, [5] data_start)
//   addr_in[31:0]                seek address, sampled on the data_start edge
//   req_addr_out/req_len_out     fetch request address and byte length
//   req_valid_out/req_ready_in   fetch request handshake
//   src_data_in/src_valid_in     source byte stream
//   src_ready_out                byte accepted when valid & ready
//   pgm_address_out/pgm_data_out buffer write address/data
//   pgm_we_n_out                 buffer write strobe, active low
//   msu_address_ext_out          read-pointer preload value (always 0)
//   msu_address_ext_write_out    read-pointer preload strobe
//   status_reset_bits_out        status bits to clear
//   status_set_bits_out          status bits to set (always 0)
//   status_reset_we_out          status update strobe
//   busy_out                     high outside IDLE and STREAM
// ---------------------------------------------------------------------------
module msu_data_feeder
    import msu_pkg::*;
#(
    parameter int HALF_BYTES = 8192,
    parameter int PULSE_CYC  = 4
) (
    input  logic        clkin,
    input  logic        rst_n,
    input  logic [7:0]  status_in,
    input  logic [31:0] addr_in,
    output logic [31:0] req_addr_out,
    output logic [14:0] req_len_out,
    output logic        req_valid_out,
    input  logic        req_ready_in,
    input  logic [7:0]  src_data_in,
    input  logic        src_valid_in,
    output logic        src_ready_out,
    output logic [13:0] pgm_address_out,
    output logic [7:0]  pgm_data_out,
    output logic        pgm_we_n_out,
    output logic [13:0] msu_address_ext_out,
    output logic        msu_address_ext_write_out,
    output logic [5:0]  status_reset_bits_out,
    output logic [5:0]  status_set_bits_out,
    output logic        status_reset_we_out,
    output logic        busy_out
);

    localparam logic [LEN_W-1:0]      FULL_LEN  = LEN_W'(2 * HALF_BYTES);
    localparam logic [LEN_W-1:0]      HALF_LEN  = LEN_W'(HALF_BYTES);
    localparam logic [BUF_ADDR_W-1:0] HALF_PTR  = BUF_ADDR_W'(HALF_BYTES);
    localparam logic [31:0]           FULL_STEP = 32'(2 * HALF_BYTES);
    localparam logic [31:0]           HALF_STEP = 32'(HALF_BYTES);

    feed_state_e           r_state;
    logic                  r_start_q;
    logic [31:0]           r_seek_addr;
    logic [31:0]           r_next_fetch;
    logic [31:0]           r_req_addr;
    logic [LEN_W-1:0]      r_req_len;
    logic                  r_req_valid;
    logic [BUF_ADDR_W-1:0] r_wr_ptr;
    logic [LEN_W-1:0]      r_remain;
    logic                  r_is_fill;
    logic                  r_last_half;
    logic                  r_refill_pend;
    logic                  r_seek_pend;
    logic [BUF_ADDR_W-1:0] r_pgm_addr;
    logic [7:0]            r_pgm_data;
    logic                  r_pgm_we_n;
    logic [5:0]            r_rst_bits;

    logic        w_seek_edge;
    logic        w_ptr13;
    logic        w_src_ready;
    logic        w_accept;
    logic        w_chunk_done;
    logic        w_do_seek;
    logic [31:0] w_seek_target;
    logic        w_do_refill;
    logic        w_strb_start;
    logic        w_strobe;
    logic        w_strb_done;
    logic        w_unused_status;

    assign w_unused_status = &{status_in[6], status_in[4:0]};

    assign w_seek_edge  = status_in[ST_DATA_START] && !r_start_q;
    assign w_ptr13      = status_in[ST_PTR13];
    assign w_src_ready  = (r_state == ST_FILL || r_state == ST_REFILL) && (r_remain != '0);
    assign w_accept     = w_src_ready && src_valid_in;
    assign w_chunk_done = (r_state == ST_FILL || r_state == ST_REFILL) && (r_remain == '0);

    // A seek is started from IDLE/STREAM directly, or at the end of a chunk
    // when one arrived (earlier or this very cycle) while the source was busy.
    always_comb begin
        w_do_seek     = 1'b0;
        w_seek_target = addr_in;
        w_do_refill   = 1'b0;
        case (r_state)
            ST_IDLE: w_do_seek = w_seek_edge;
            ST_STREAM: begin
                w_do_seek   = w_seek_edge;
                w_do_refill = !w_seek_edge && ((w_ptr13 != r_last_half) || r_refill_pend);
            end
            ST_FILL, ST_REFILL: begin
                w_do_seek     = w_chunk_done && (r_seek_pend || w_seek_edge);
                w_seek_target = w_seek_edge ? addr_in : r_seek_addr;
            end
            default: ;
        endcase
    end

    assign w_strb_start = (w_chunk_done && r_state == ST_FILL && !w_do_seek)
                       || (r_state == ST_PRELOAD && w_strb_done);

    msu_strobe_gen #(
        .PULSE_CYC (PULSE_CYC)
    ) u_strobe (
        .clkin    (clkin),
        .rst_n    (rst_n),
        .i_start  (w_strb_start),
        .o_strobe (w_strobe),
        .o_done   (w_strb_done)
    );

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            // Treat data_start already high at reset release as a level, not a seek.
            r_start_q     <= 1'b1;
            r_seek_addr   <= '0;
            r_next_fetch  <= '0;
            r_req_addr    <= '0;
            r_req_len     <= '0;
            r_req_valid   <= 1'b0;
            r_wr_ptr      <= '0;
            r_remain      <= '0;
            r_is_fill     <= 1'b0;
            r_last_half   <= 1'b0;
            r_refill_pend <= 1'b0;
            r_seek_pend   <= 1'b0;
            r_pgm_addr    <= '0;
            r_pgm_data    <= '0;
            r_pgm_we_n    <= 1'b1;
            r_rst_bits    <= '0;
        end else begin
            r_start_q  <= status_in[ST_DATA_START];
            r_pgm_we_n <= 1'b1;

            if (w_accept) begin
                r_pgm_addr <= r_wr_ptr;
                r_pgm_data <= src_data_in;
                r_pgm_we_n <= 1'b0;
                r_wr_ptr   <= r_wr_ptr + 1'b1;
                r_remain   <= r_remain - 1'b1;
            end

            if (w_do_seek) begin
                r_state       <= ST_REQ;
                r_req_addr    <= w_seek_target;
                r_req_len     <= FULL_LEN;
                r_req_valid   <= 1'b1;
                r_wr_ptr      <= '0;
                r_remain      <= FULL_LEN;
                r_is_fill     <= 1'b1;
                r_seek_addr   <= w_seek_target;
                r_seek_pend   <= 1'b0;
                r_refill_pend <= 1'b0;
            end else if (w_do_refill) begin
                // Refill the half the SNES is not reading.
                r_state       <= ST_REQ;
                r_last_half   <= w_ptr13;
                r_refill_pend <= 1'b0;
                r_req_addr    <= r_next_fetch;
                r_req_len     <= HALF_LEN;
                r_req_valid   <= 1'b1;
                r_wr_ptr      <= w_ptr13 ? '0 : HALF_PTR;
                r_remain      <= HALF_LEN;
                r_is_fill     <= 1'b0;
            end else begin
                // The source cannot abort a chunk: seeks and half toggles seen
                // while it is busy are remembered and served afterwards.
                if ((r_state == ST_REQ || r_state == ST_FILL || r_state == ST_REFILL)
                        && w_seek_edge) begin
                    r_seek_pend <= 1'b1;
                    r_seek_addr <= addr_in;
                end
                if ((r_state == ST_REQ || r_state == ST_REFILL) && !r_is_fill
                        && (w_ptr13 != r_last_half)) begin
                    r_refill_pend <= 1'b1;
                    r_last_half   <= w_ptr13;
                end

                case (r_state)
                    ST_REQ: begin
                        if (req_ready_in) begin
                            r_req_valid <= 1'b0;
                            r_state     <= r_is_fill ? ST_FILL : ST_REFILL;
                        end
                    end
                    ST_FILL: begin
                        if (w_chunk_done) r_state <= ST_PRELOAD;
                    end
                    ST_PRELOAD: begin
                        if (w_strb_done) begin
                            r_state    <= ST_CLRBUSY;
                            r_rst_bits <= CLR_BUSY_BITS;
                        end
                    end
                    ST_CLRBUSY: begin
                        if (w_strb_done) begin
                            r_state      <= ST_STREAM;
                            r_rst_bits   <= '0;
                            r_last_half  <= 1'b0;
                            r_next_fetch <= r_seek_addr + FULL_STEP;
                        end
                    end
                    ST_REFILL: begin
                        if (w_chunk_done) begin
                            r_state      <= ST_STREAM;
                            r_next_fetch <= r_next_fetch + HALF_STEP;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign req_addr_out              = r_req_addr;
    assign req_len_out               = r_req_len;
    assign req_valid_out             = r_req_valid;
    assign src_ready_out             = w_src_ready;
    assign pgm_address_out           = r_pgm_addr;
    assign pgm_data_out              = r_pgm_data;
    assign pgm_we_n_out              = r_pgm_we_n;
    assign msu_address_ext_out       = '0;
    // The sequencer output is low whenever the state changes, so gating by
    // state cannot produce a runt pulse.
    assign msu_address_ext_write_out = w_strobe && (r_state == ST_PRELOAD);
    assign status_reset_we_out       = w_strobe && (r_state == ST_CLRBUSY);
    assign status_reset_bits_out     = r_rst_bits;
    assign status_set_bits_out       = '0;
    assign busy_out                  = !(r_state == ST_IDLE || r_state == ST_STREAM);

endmodule
